fetch_branch_unit: RTL and testbench

Instruction-fetch and control-flow stage of the lab 7 CPU, sitting between the instruction/data RAM and the decode/execute datapath. Holds the program counter, fetches one 16-bit instruction per pass over a synchronous-read memory, and resolves all control-flow instructions locally: B/BEQ/BNE/BLT/BLE, BL/BX/BLX and HALT. Hands every other instruction to the execute stage with a valid/done handshake. Drives the halt indication that the top level routes to LEDR[8].

---
 rtl/fetch_branch_unit_if.sv | 40 ++++
 rtl/fetch_branch_unit.sv | 156 +++++++++++++++
 tb/tb_fetch_branch_unit.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_branch_unit_if.sv
// Bus bundle between fetch_branch_unit, the instruction RAM, the register
// file and the execute stage.
//
// Handshake: instr_valid is high while instr holds a non-control-flow
// instruction waiting for execution; instr and instr_valid do not change
// until the execute stage answers with exec_done, and that transfer completes
// on the first rising edge where both are high. exec_done is ignored
// whenever instr_valid is low.
interface fetch_branch_unit_if #(
    parameter int PC_W = 9
);
    logic [PC_W-1:0] mem_addr;
    logic            mem_rd;
    logic [15:0]     mem_rdata;
    logic [15:0]     instr;
    logic            instr_valid;
    logic            exec_done;
    logic            flag_z;
    logic            flag_n;
    logic            flag_v;
    logic [2:0]      rd_idx;
    logic [15:0]     rd_data;
    logic            link_we;
    logic [15:0]     link_data;
    logic [PC_W-1:0] pc;
    logic            halted;
    logic [2:0]      dbg_state;

    modport master (
        output mem_addr, mem_rd, instr, instr_valid, rd_idx,
               link_we, link_data, pc, halted, dbg_state,
        input  mem_rdata, exec_done, flag_z, flag_n, flag_v, rd_data
    );

    modport slave (
        input  mem_addr, mem_rd, instr, instr_valid, rd_idx,
               link_we, link_data, pc, halted, dbg_state,
        output mem_rdata, exec_done, flag_z, flag_n, flag_v, rd_data
    );
endinterface

// File: rtl/fetch_branch_unit.sv
// Fetch and control-flow stage: holds the PC, fetches one instruction per
// pass over a synchronous-read RAM, resolves branches / links / HALT locally
// and hands everything else to the execute stage.
// Optional feature macro: BRANCH_LINK_EN enables BL, BX and BLX; without it
// every opcode-010 instruction halts the machine.
module fetch_branch_unit #(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    fetch_branch_unit_if.master bus
);

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic            halted_q, halted_d;
    logic            link_we_c;
    logic            mem_rd_c;
    logic            instr_valid_c;
    logic            taken;
    logic [PC_W-1:0] pc_plus1;
    logic [PC_W-1:0] pc_rel;
    logic [PC_W-1:0] offset;
    logic            unused_bits;

    // PC arithmetic wraps naturally at PC_W bits
    assign pc_plus1 = pc_q + PC_W'(1);
    assign offset   = PC_W'($signed(ir_q[7:0]));
    assign pc_rel   = pc_plus1 + offset;

    // Branch condition from IR[10:8] and the CMP flags
    always_comb begin
        taken = 1'b0;
        case (ir_q[10:8])
            3'b000:  taken = 1'b1;
            3'b001:  taken = bus.flag_z;
            3'b010:  taken = ~bus.flag_z;
            3'b011:  taken = bus.flag_n ^ bus.flag_v;
            3'b100:  taken = (bus.flag_n ^ bus.flag_v) | bus.flag_z;
            default: taken = 1'b0;
        endcase
    end

    // Next-state, next-PC and per-state strobes
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        halted_d      = halted_q;
        link_we_c     = 1'b0;
        mem_rd_c      = 1'b0;
        instr_valid_c = 1'b0;
        case (state_q)
            S_RST: begin
                pc_d    = RESET_PC;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_rd_c = 1'b1;
                state_d  = S_LOAD;
            end
            S_LOAD: begin
                ir_d    = bus.mem_rdata;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_FETCH;
                case (ir_q[15:13])
                    3'b001: pc_d = taken ? pc_rel : pc_plus1;
                    3'b010: begin
`ifdef BRANCH_LINK_EN
                        case (ir_q[12:11])
                            2'b11: begin
                                link_we_c = 1'b1;
                                pc_d      = pc_rel;
                            end
                            2'b00: pc_d = bus.rd_data[PC_W-1:0];
                            2'b10: begin
                                link_we_c = 1'b1;
                                pc_d      = bus.rd_data[PC_W-1:0];
                            end
                            default: begin
                                halted_d = 1'b1;
                                state_d  = S_HALT;
                            end
                        endcase
`else
                        halted_d = 1'b1;
                        state_d  = S_HALT;
`endif
                    end
                    3'b111: begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                instr_valid_c = 1'b1;
                if (bus.exec_done) begin
                    pc_d    = pc_plus1;
                    state_d = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    // State, PC, IR and sticky halt registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_RST;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
        end
    end

    assign bus.mem_addr    = pc_q;
    assign bus.pc          = pc_q;
    assign bus.mem_rd      = mem_rd_c;
    assign bus.instr       = ir_q;
    assign bus.instr_valid = instr_valid_c;
    assign bus.halted      = halted_q;
    assign bus.link_data   = 16'(pc_plus1);
    assign bus.dbg_state   = state_q;

`ifdef BRANCH_LINK_EN
    assign bus.link_we  = link_we_c;
    assign bus.rd_idx   = ir_q[7:5];
    assign unused_bits  = ^bus.rd_data[15:PC_W];
`else
    assign bus.link_we  = 1'b0;
    assign bus.rd_idx   = 3'd0;
    assign unused_bits  = ^{bus.rd_data, ir_q[12:11], link_we_c};
`endif

endmodule

// File: tb/tb_fetch_branch_unit.sv
// Bench for fetch_branch_unit: RAM model, register-file model, directed
// scenarios and randomized instruction streams checked against an
// instruction-level reference model.
module tb_fetch_branch_unit;

    localparam int PC_W   = 9;
    localparam int PC_MOD = 512;
    localparam int K_CF   = 0;
    localparam int K_EXEC = 1;
    localparam int K_HALT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] mem [0:PC_MOD-1];
    logic [15:0] reg_file [0:7];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_pc = 0;

    fetch_branch_unit_if #(.PC_W(PC_W)) bus();

    fetch_branch_unit #(.PC_W(PC_W), .RESET_PC(9'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock
    always #5 clk = ~clk;

    // synchronous-read RAM
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    end

    // combinational register-file read port
    assign bus.rd_data = reg_file[bus.rd_idx];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int wrap(input int x);
        return ((x % PC_MOD) + PC_MOD) % PC_MOD;
    endfunction

    // instruction-level reference: next PC, instruction kind, link write count
    function automatic void predict(input logic [15:0] w, input int pc, input logic z,
                                    input logic n, input logic v, output int npc,
                                    output int kind, output int link);
        int  off;
        bit  tk;
        logic [7:0] imm;
        imm  = w[7:0];
        off  = (imm >= 128) ? int'(imm) - 256 : int'(imm);
        npc  = wrap(pc + 1);
        kind = K_EXEC;
        link = 0;
        if (w[15:13] == 3'b001) begin
            kind = K_CF;
            case (w[10:8])
                3'd0:    tk = 1;
                3'd1:    tk = z;
                3'd2:    tk = !z;
                3'd3:    tk = (n != v);
                3'd4:    tk = (n != v) || z;
                default: tk = 0;
            endcase
            if (tk) npc = wrap(pc + 1 + off);
        end else if (w[15:13] == 3'b010) begin
`ifdef BRANCH_LINK_EN
            kind = K_CF;
            if (w[12:11] == 2'b11) begin
                link = 1;
                npc  = wrap(pc + 1 + off);
            end else if (w[12:11] == 2'b00) begin
                npc = int'(reg_file[w[7:5]]) % PC_MOD;
            end else if (w[12:11] == 2'b10) begin
                link = 1;
                npc  = int'(reg_file[w[7:5]]) % PC_MOD;
            end else begin
                kind = K_HALT;
                npc  = pc;
            end
`else
            kind = K_HALT;
            npc  = pc;
`endif
        end else if (w[15:13] == 3'b111) begin
            kind = K_HALT;
            npc  = pc;
        end
    endfunction

    // one-cycle reset from a negedge, then wait for the first fetch
    task automatic do_reset();
        int cnt;
        reset = 1'b1;
        bus.exec_done = 1'b1;
        @(negedge clk);
        check_eq("rst_pc", bus.pc, 0);
        check_eq("rst_mem_rd", bus.mem_rd, 0);
        check_eq("rst_instr_valid", bus.instr_valid, 0);
        check_eq("rst_link_we", bus.link_we, 0);
        check_eq("rst_halted", bus.halted, 0);
        check_eq("rst_instr", bus.instr, 0);
        reset = 1'b0;
        bus.exec_done = 1'b0;
        cnt = 0;
        while (!bus.mem_rd && cnt < 8) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("first_fetch_delay", cnt, 1);
        check_eq("first_fetch_addr", bus.mem_addr, 0);
        m_pc = 0;
    endtask

    // drive one instruction from its FETCH cycle to the next FETCH (or halt)
    task automatic exec_instr(input logic [15:0] word, input logic z, input logic n,
                              input logic v, input int wait_cycles);
        int exp_pc, kind, link;
        int cyc, n_exec, n_link;
        bit done;
        check_eq("fetch_rd", bus.mem_rd, 1);
        check_eq("fetch_addr", bus.mem_addr, m_pc);
        mem[m_pc]  = word;
        bus.flag_z = z;
        bus.flag_n = n;
        bus.flag_v = v;
        predict(word, m_pc, z, n, v, exp_pc, kind, link);
        cyc = 0; n_exec = 0; n_link = 0; done = 0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (bus.link_we) begin
                n_link++;
                check_eq("link_data", bus.link_data, wrap(m_pc + 1));
            end
            if (bus.instr_valid) begin
                check_eq("instr", bus.instr, word);
                bus.exec_done = (n_exec == wait_cycles);
                n_exec++;
            end else begin
                bus.exec_done = 1'($urandom_range(0, 1));
            end
            if (bus.mem_rd || bus.halted) done = 1;
        end
        check_eq("instr_timeout", done, 1);
        check_eq("link_count", n_link, link);
        if (kind == K_HALT) begin
            check_eq("halt_cycles", cyc, 3);
            check_eq("halted", bus.halted, 1);
            check_eq("halt_pc", bus.pc, m_pc);
        end else begin
            if (kind == K_CF) begin
                check_eq("cf_cycles", cyc, 3);
                check_eq("cf_no_valid", n_exec, 0);
            end else begin
                check_eq("exec_cycles", cyc, 4 + wait_cycles);
            end
            check_eq("next_pc", bus.pc, exp_pc);
            check_eq("next_addr", bus.mem_addr, exp_pc);
            m_pc = exp_pc;
        end
    endtask

    // unconditional branches until the PC reaches target
    task automatic jump_to(input int target);
        int d;
        int hops;
        hops = 0;
        while (m_pc != target && hops < 8) begin
            d = wrap(target - m_pc - 1);
            if (d >= 256) d -= 512;
            if (d > 127) d = 127;
            if (d < -128) d = -128;
            exec_instr(16'h2000 | 16'(d & 8'hFF), 1'b0, 1'b0, 1'b0, 0);
            hops++;
        end
        check_eq("jump_reached", m_pc, target);
    endtask

    // halted machine stays idle
    task automatic halt_hold(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            bus.exec_done = 1'($urandom_range(0, 1));
            check_eq("hold_mem_rd", bus.mem_rd, 0);
            check_eq("hold_pc", bus.pc, m_pc);
            check_eq("hold_halted", bus.halted, 1);
        end
    endtask

    // reset in the middle of an EXEC handshake
    task automatic reset_mid_exec();
        int cnt;
        mem[m_pc] = 16'h1234;
        bus.exec_done = 1'b0;
        cnt = 0;
        while (!bus.instr_valid && cnt < 10) begin
            @(negedge clk);
            bus.exec_done = 1'b0;
            cnt++;
        end
        check_eq("mid_exec_reached", bus.instr_valid, 1);
        @(negedge clk);
        check_eq("mid_exec_waiting", bus.instr_valid, 1);
        do_reset();
    endtask

    initial begin
        logic [2:0]  opc;
        logic [12:0] low;
        logic [15:0] word;
        int          r;
        for (int i = 0; i < PC_MOD; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 8; i++) reg_file[i] = 16'h0000;
        bus.exec_done = 1'b0;
        bus.flag_z = 1'b0;
        bus.flag_n = 1'b0;
        bus.flag_v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // MOV at reset PC, immediate exec_done
        exec_instr(16'hD005, 1'b0, 1'b0, 1'b0, 0);
        check_eq("mov_pc", bus.pc, 1);

        // BNE taken / not taken
        jump_to(4);
        exec_instr(16'h2201, 1'b0, 1'b0, 1'b0, 0);
        check_eq("bne_taken", m_pc, 6);
        jump_to(4);
        exec_instr(16'h2201, 1'b1, 1'b0, 1'b0, 0);
        check_eq("bne_not_taken", m_pc, 5);

        // BLT backwards taken / not taken
        jump_to(16);
        exec_instr(16'h23FC, 1'b0, 1'b1, 1'b0, 0);
        check_eq("blt_taken", m_pc, 13);
        jump_to(16);
        exec_instr(16'h23FC, 1'b0, 1'b0, 1'b0, 0);
        check_eq("blt_not_taken", m_pc, 17);

`ifdef BRANCH_LINK_EN
        jump_to(3);
        exec_instr(16'h5805, 1'b0, 1'b0, 1'b0, 0);
        check_eq("bl_pc", m_pc, 9);
        reg_file[3] = 16'h0004;
        exec_instr(16'h4060, 1'b0, 1'b0, 1'b0, 0);
        check_eq("bx_pc", m_pc, 4);
`else
        jump_to(3);
        exec_instr(16'h5805, 1'b0, 1'b0, 1'b0, 0);
        halt_hold(3);
        do_reset();
`endif

        // PC wrap on an executed instruction
        jump_to(9'h1FF);
        exec_instr(16'h1234, 1'b0, 1'b0, 1'b0, 2);
        check_eq("wrap_pc", m_pc, 0);

        // reset during EXEC
        jump_to(5);
        reset_mid_exec();

        // HALT at 0xE
        jump_to(14);
        exec_instr(16'hE000, 1'b0, 1'b0, 1'b0, 0);
        halt_hold(20);
        do_reset();

        // randomized instruction stream
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 8; i++) reg_file[i] = 16'($urandom);
            r   = $urandom_range(0, 19);
            low = 13'($urandom);
            if (r < 9)       opc = 3'b001;
            else if (r < 13) opc = 3'b010;
            else if (r == 13) opc = 3'b111;
            else begin
                case ($urandom_range(0, 4))
                    0:       opc = 3'b000;
                    1:       opc = 3'b011;
                    2:       opc = 3'b100;
                    3:       opc = 3'b101;
                    default: opc = 3'b110;
                endcase
            end
            word = {opc, low};
            exec_instr(word, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3));
            if (bus.halted) begin
                halt_hold(4);
                do_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // global time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
